mem_block_responder: RTL and testbench

Main-memory side of the cache line-fill interface. It is the responder that the direct-mapped cache's miss path initiates requests to.
- Accepts one block-read request at a time.
- Models fixed access latency, then reads WORDS_PER_BLOCK consecutive words from a word-addressed array.
- Returns them as one packed line with a valid/ready handshake.
- A side write port preloads or updates memory contents (bench init, future write path).

---
 rtl/mem_block_responder_pkg.sv | 17 +
 rtl/mem_block_responder_array.sv | 19 +
 rtl/mem_block_responder.sv | 83 ++++++++
 tb/tb_mem_block_responder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_block_responder_pkg.sv
// mem_block_responder_pkg: shared widths, responder states and block addressing helper
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 16
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
package mem_block_responder_pkg;
  localparam int ADDR_LEN = `ADDRESS_LEN;
  localparam int WORD_LEN = `WORD_LEN;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int LINE_W = WORDS_PER_BLOCK * WORD_LEN;
  typedef enum logic [1:0] {IDLE, WAIT, FETCH, RESP} resp_state_t;
  function automatic logic [ADDR_LEN-1:0] block_base(input logic [ADDR_LEN-1:0] addr);
    return addr & ~ADDR_LEN'(WORDS_PER_BLOCK - 1);
  endfunction
endpackage

// File: rtl/mem_block_responder_array.sv
// mem_word_array: word storage with one write port and one synchronous read-first read port
module mem_word_array #(
  parameter int WORD_W = 32,
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end
endmodule

// File: rtl/mem_block_responder.sv
// mem_block_responder: fixed-latency block-read responder feeding cache line fills
module mem_block_responder
  import mem_block_responder_pkg::*;
#(
  parameter int ADDR_W = mem_block_responder_pkg::ADDR_LEN,
  parameter int WORD_W = mem_block_responder_pkg::WORD_LEN,
  parameter int WORDS_PER_BLOCK = mem_block_responder_pkg::WORDS_PER_BLOCK,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_W-1:0]                 req_addr,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [WORDS_PER_BLOCK*WORD_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]                 rsp_addr,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [WORD_W-1:0]                 wr_data,
  output logic                              busy
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int BEAT_W = WORDS_PER_BLOCK > 1 ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int CNT_W = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  resp_state_t state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] base, rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic last_beat;
  assign base = ADDR_W'(block_base(ADDR_LEN'(req_addr)));
  assign last_beat = beat == BEAT_W'(WORDS_PER_BLOCK - 1);
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  // reads run one beat ahead so each FETCH cycle stores a word already on rd_data
  assign rd_addr = state == FETCH ? rsp_addr + ADDR_W'(beat) + ADDR_W'(1) : state == IDLE ? base : rsp_addr;
  mem_word_array #(.WORD_W(WORD_W), .DEPTH(MEM_WORDS)) u_array (
    .clk(clk),
    .wr_en(wr_en),
    .wr_idx(IDX_W'(wr_addr % ADDR_W'(MEM_WORDS))),
    .wr_data(wr_data),
    .rd_idx(IDX_W'(rd_addr % ADDR_W'(MEM_WORDS))),
    .rd_data(rd_data)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) begin
        if (LATENCY == 0) state_nx = FETCH;
        else state_nx = WAIT;
      end
      WAIT: if (wait_cnt == CNT_W'(1)) state_nx = FETCH;
      FETCH: if (last_beat) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      wait_cnt <= '0;
      beat <= '0;
      rsp_addr <= '0;
      rsp_data <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        rsp_addr <= base;
        wait_cnt <= CNT_W'(LATENCY);
        beat <= '0;
      end
      if (state == WAIT) wait_cnt <= wait_cnt - CNT_W'(1);
      if (state == FETCH) begin
        rsp_data[beat*WORD_W +: WORD_W] <= rd_data;
        beat <= beat + BEAT_W'(1);
      end
    end
endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder: scoreboard bench for the block-read responder (default and zero-latency builds)
module tb_mem_block_responder;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_valid0 = 0, rsp_ready = 1, rsp_ready0 = 1, wr_en = 0;
  logic [15:0] req_addr = 0, wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic req_ready, rsp_valid, busy, req_ready0, rsp_valid0, busy0;
  logic [127:0] rsp_data, rsp_data0;
  logic [15:0] rsp_addr, rsp_addr0;
  logic seen;
  typedef struct {logic [15:0] a; logic [127:0] d;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, cyc = 0, acc = 0;
  localparam logic [127:0] LINE = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_BAD = 128'h44444444_33333333_DEADBEEF_11111111;
  localparam logic [127:0] WRAP = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam logic [127:0] LOW = 128'hB0000003_B0000002_B0000001_B0000000;
  always #5 clk = ~clk;
  mem_block_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  mem_block_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0), .rsp_addr(rsp_addr0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy0)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic accept(input bit sel, input logic [15:0] a, input logic [15:0] ea, input logic [127:0] ed);
    sb.push_back('{ea, ed});
    req_addr = a;
    if (sel) req_valid0 = 1;
    else req_valid = 1;
    check("req_ready", sel ? req_ready0 : req_ready, 1);
    tick();
    acc = cyc;
    req_valid = 0;
    req_valid0 = 0;
  endtask
  task automatic wait_rsp(input bit sel, input int lat);
    exp_t e;
    for (int i = 0; i < 40 && !(sel ? rsp_valid0 : rsp_valid); i++) tick();
    check("latency", cyc - acc, lat);
    if (sb.size() == 0) check("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      check("rsp_addr", sel ? rsp_addr0 : rsp_addr, e.a);
      check("rsp_data", sel ? rsp_data0 : rsp_data, e.d);
    end
  endtask
  initial begin
    repeat (2) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      wr(16'(16'h40 + i), 32'(32'h11111111 * (i + 1)));
      wr(16'(i), 32'(32'hA0000000 + i));
      wr(16'(4 + i), 32'(32'hB0000000 + i));
    end
    accept(0, 16'h42, 16'h40, LINE);
    wait_rsp(0, 8);
    tick();
    check("idle_valid", rsp_valid, 0);
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    rsp_ready = 0;
    accept(0, 16'h42, 16'h40, LINE);
    wait_rsp(0, 8);
    req_addr = 16'h1001;
    req_valid = 1;
    sb.push_back('{16'h1000, WRAP});
    repeat (5) begin
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, LINE);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 1;
    tick();
    check("hs_ready", req_ready, 1);
    check("hs_valid", rsp_valid, 0);
    tick();
    acc = cyc;
    req_valid = 0;
    check("second_busy", busy, 1);
    wait_rsp(0, 8);
    tick();
    accept(1, 16'h7, 16'h4, LOW);
    wait_rsp(1, 4);
    tick();
    check("lat0_idle", rsp_valid0, 0);
    accept(0, 16'h40, 16'h40, LINE_BAD);
    wr(16'h41, 32'hDEADBEEF);
    wait_rsp(0, 8);
    tick();
    wr(16'h41, 32'h22222222);
    accept(0, 16'h40, 16'h40, LINE);
    repeat (5) tick();
    wr(16'h41, 32'hDEADBEEF);
    wait_rsp(0, 8);
    tick();
    req_addr = 16'h40;
    req_valid = 1;
    tick();
    req_valid = 0;
    repeat (6) tick();
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", rsp_addr, 0);
    check("mid_rst_data", rsp_data, 0);
    seen = 0;
    repeat (12) begin
      tick();
      seen = seen | rsp_valid;
    end
    check("no_rsp", seen, 0);
    accept(0, 16'h43, 16'h40, LINE_BAD);
    wait_rsp(0, 8);
    tick();
    check("final_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
